ram8_arbiter: RTL

RAM8_ARBITER -- requirements
Module: ram8_arbiter

---
 rtl/ram8_ctrl_pkg.sv | 17 +
 rtl/rr_arb2.sv | 16 +
 rtl/ram8_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/ram8_ctrl_pkg.sv
// Shared types and defaults for the two-port RAM8 front end.
// Pure declarations: no latency, no flow control.
package ram8_ctrl_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 3;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_SERVE = 1'b1
    } state_e;

    function automatic state_e entry_state(input bit clear_on_reset);
        return clear_on_reset ? ST_CLEAR : ST_SERVE;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; combinational, zero latency.
// On conflict the requester that was not served last wins; a lone request always wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/ram8_arbiter.sv
// Arbitrates two requesters onto one RAM8 port, optionally zero-filling it after reset.
// Grants same cycle, read data one cycle later; no grants while busy clearing.
module ram8_arbiter
    import ram8_ctrl_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_load,
    output logic [ADDR_W-1:0] ram_address,
    input  logic [DATA_W-1:0] ram_out
);

    localparam state_e            ENTRY_ST = entry_state(CLEAR_ON_RESET);
    localparam logic [ADDR_W-1:0] CLR_LAST = '1;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic                last_q, last_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rvalid0_q, rvalid0_d;
    logic                rvalid1_q, rvalid1_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [1:0]          arb_gnt;

    rr_arb2 u_arb (
        .req  ({req1, req0}),
        .last (last_q),
        .gnt  (arb_gnt)
    );

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        last_d      = last_q;
        rdata_d     = rdata_q;
        rvalid0_d   = 1'b0;
        rvalid1_d   = 1'b0;
        busy        = 1'b0;
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        ram_load    = 1'b0;
        ram_in      = '0;
        ram_address = addr_q;

        case (state_q)
            ST_CLEAR: begin
                busy        = 1'b1;
                ram_load    = 1'b1;
                ram_address = clr_cnt_q;
                clr_cnt_d   = clr_cnt_q + 1'b1;
                if (clr_cnt_q == CLR_LAST) begin
                    state_d = ST_SERVE;
                end
            end
            ST_SERVE: begin
                gnt0 = arb_gnt[0];
                gnt1 = arb_gnt[1];
                if (arb_gnt[0]) begin
                    ram_address = addr0;
                    ram_in      = wdata0;
                    ram_load    = we0;
                    last_d      = 1'b0;
                    if (!we0) begin
                        rvalid0_d = 1'b1;
                        rdata_d   = ram_out;
                    end
                end else if (arb_gnt[1]) begin
                    ram_address = addr1;
                    ram_in      = wdata1;
                    ram_load    = we1;
                    last_d      = 1'b1;
                    if (!we1) begin
                        rvalid1_d = 1'b1;
                        rdata_d   = ram_out;
                    end
                end
            end
        endcase
    end

    // addr_q follows the driven address so idle cycles keep the RAM pointed at the last access.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ENTRY_ST;
            clr_cnt_q <= '0;
            last_q    <= 1'b1;
            rdata_q   <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            last_q    <= last_d;
            rdata_q   <= rdata_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            addr_q    <= ram_address;
        end
    end

    assign rdata   = rdata_q;
    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;

endmodule
